// File: rtl/count_tracker.sv
// Downstream monitor for a free-running counter: wrap epoch tracking, armed/hit compare FSM
// and a single-entry timestamp event output. Optional step checker: COUNT_TRACKER_STEP_CHECK_EN.
module count_tracker #(
  parameter int CNT_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         count,
  input  logic [CNT_W-1:0]         cmp_val,
  input  logic                     cmp_load,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     cont,
  output logic                     match_pulse,
  output logic                     wrap_pulse,
  output logic [WRAP_W-1:0]        wrap_cnt,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [WRAP_W+CNT_W-1:0]  evt_data,
  output logic                     evt_ovf,
  output logic                     step_err,
  output logic                     armed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               hit_now;
  logic               wrap_det;
  logic [CNT_W-1:0]   prev_count;
  logic [CNT_W-1:0]   cmp_reg;
  logic [WRAP_W-1:0]  wrap_cnt_next;

  assign wrap_det      = (prev_count == {CNT_W{1'b1}}) && (count == {CNT_W{1'b0}});
  assign wrap_cnt_next = wrap_cnt + {{(WRAP_W-1){1'b0}}, wrap_det};

  // Next-state logic; disarm overrides every other request.
  always_comb begin
    state_next = state;
    hit_now    = 1'b0;
    if (disarm) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_next = ARMED;
          end else begin
            state_next = IDLE;
          end
        end
        ARMED: begin
          if (count == cmp_reg) begin
            state_next = HIT;
            hit_now    = 1'b1;
          end else begin
            state_next = ARMED;
          end
        end
        HIT: begin
          if (cont) begin
            state_next = ARMED;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, sampled counter history, compare register and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev_count  <= {CNT_W{1'b0}};
      cmp_reg     <= {CNT_W{1'b0}};
      wrap_cnt    <= {WRAP_W{1'b0}};
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_next;
      prev_count  <= count;
      wrap_cnt    <= wrap_cnt_next;
      wrap_pulse  <= wrap_det;
      match_pulse <= hit_now;
      armed       <= (state_next == ARMED);
      if (cmp_load) begin
        cmp_reg <= cmp_val;
      end else begin
        cmp_reg <= cmp_reg;
      end
    end
  end

  // Single-entry event slot: a hit into a full, unaccepted slot is dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_data  <= {(WRAP_W+CNT_W){1'b0}};
      evt_ovf   <= 1'b0;
    end else begin
      if (hit_now) begin
        if (!evt_valid || evt_ready) begin
          evt_data  <= {wrap_cnt_next, count};
          evt_valid <= 1'b1;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end else begin
        evt_valid <= evt_valid;
      end
    end
  end

`ifdef COUNT_TRACKER_STEP_CHECK_EN
  logic step_live;
  logic step_bad;

  assign step_bad = (count != (prev_count + {{(CNT_W-1){1'b0}}, 1'b1})) && (count != prev_count);

  // prev_count holds a reset value, not a real sample, on the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_live <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      step_live <= 1'b1;
      if (step_live && step_bad) begin
        step_err <= 1'b1;
      end else begin
        step_err <= step_err;
      end
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_tracker.sv
// Self-checking bench for count_tracker: directed scenarios followed by randomized stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_count_tracker;

`ifdef COUNT_TRACKER_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_ARMED = 2'd1;
  localparam logic [1:0] M_HIT   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count;
  logic [7:0]  cmp_val;
  logic        cmp_load, arm, disarm, cont, evt_ready;
  logic        match_pulse, wrap_pulse, evt_valid, evt_ovf, step_err, armed;
  logic [7:0]  wrap_cnt;
  logic [15:0] evt_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [7:0]  m_prev, m_cmp, m_wrap;
  logic [1:0]  m_mode;
  logic [15:0] m_evt_data;
  logic        m_evt_valid, m_ovf, m_step, m_match, m_wpulse, m_armed, m_first;

  count_tracker #(.CNT_W(8), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .count(count), .cmp_val(cmp_val), .cmp_load(cmp_load),
    .arm(arm), .disarm(disarm), .cont(cont), .match_pulse(match_pulse),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .evt_ovf(evt_ovf),
    .step_err(step_err), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 8'h00; m_cmp = 8'h00; m_wrap = 8'h00; m_mode = M_IDLE;
    m_evt_data = 16'h0000; m_evt_valid = 1'b0; m_ovf = 1'b0; m_step = 1'b0;
    m_match = 1'b0; m_wpulse = 1'b0; m_armed = 1'b0; m_first = 1'b1;
  endtask

  task automatic model_step();
    logic       wrap;
    logic       hit;
    logic [7:0] w_next;
    logic [1:0] mode_n;
    wrap   = (m_prev == 8'hFF) && (count == 8'h00);
    w_next = m_wrap + (wrap ? 8'd1 : 8'd0);
    hit    = (m_mode == M_ARMED) && !disarm && (count == m_cmp);
    if (disarm)                 mode_n = M_IDLE;
    else if (m_mode == M_IDLE)  mode_n = arm ? M_ARMED : M_IDLE;
    else if (m_mode == M_ARMED) mode_n = hit ? M_HIT : M_ARMED;
    else                        mode_n = cont ? M_ARMED : M_IDLE;
    if (hit) begin
      if (!m_evt_valid || evt_ready) begin
        m_evt_data  = {w_next, count};
        m_evt_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_evt_valid && evt_ready) begin
      m_evt_valid = 1'b0;
    end
    if (STEP_EN && !m_first && (count != m_prev + 8'd1) && (count != m_prev)) m_step = 1'b1;
    m_first  = 1'b0;
    m_match  = hit;
    m_wpulse = wrap;
    m_armed  = (mode_n == M_ARMED);
    m_mode   = mode_n;
    m_prev   = count;
    m_wrap   = w_next;
    if (cmp_load) m_cmp = cmp_val;
  endtask

  task automatic compare_all();
    check("match_pulse", match_pulse, m_match);
    check("wrap_pulse", wrap_pulse, m_wpulse);
    check("wrap_cnt", wrap_cnt, m_wrap);
    check("evt_valid", evt_valid, m_evt_valid);
    check("evt_data", evt_data, m_evt_data);
    check("evt_ovf", evt_ovf, m_ovf);
    check("step_err", step_err, m_step);
    check("armed", armed, m_armed);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {match_pulse, wrap_pulse, evt_valid, evt_ovf, step_err, armed}, 32'd0);
    check({tag, "_wrap_cnt"}, wrap_cnt, 32'd0);
    check({tag, "_evt_data"}, evt_data, 32'd0);
  endtask

  // one clock: model and DUT see the same inputs, outputs compared after the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    count = count + 8'd1;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_match(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      seen = match_pulse;
    end
    check({tag, "_match_seen"}, seen, 1'b1);
  endtask

  task automatic wait_count(input string tag, input logic [7:0] val);
    bit seen;
    seen = (count == val);
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = (count == val);
    end
    check({tag, "_count_reached"}, seen, 1'b1);
  endtask

  initial begin
    logic [15:0] first_data;
    int          hits;
    reset = 1'b0; count = 8'hFD; cmp_val = 8'h00; cmp_load = 1'b0;
    arm = 1'b0; disarm = 1'b0; cont = 1'b0; evt_ready = 1'b0;
    model_reset();

    // 1: reset state, then wrap on 0xFF -> 0x00
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (4) tick();
    check("tp1_wrap_pulse", wrap_pulse, 1'b1);
    check("tp1_wrap_cnt", wrap_cnt, 8'd1);
    tick();
    check("tp1_wrap_pulse_end", wrap_pulse, 1'b0);

    // 2: single-shot hit at 0x10 with wrap_cnt 3
    cmp_val = 8'h10; cmp_load = 1'b1;
    tick();
    cmp_load = 1'b0;
    for (int i = 0; i < 600 && m_wrap != 8'd3; i++) tick();
    check("tp2_wrap3", wrap_cnt, 8'd3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("tp2_armed", armed, 1'b1);
    wait_match("tp2", 300);
    check("tp2_evt_data", evt_data, 16'h0310);
    tick();
    check("tp2_single_pulse", match_pulse, 1'b0);
    check("tp2_idle", armed, 1'b0);
    check("tp2_valid_held", evt_valid, 1'b1);

    // 3: continuous mode, overflow, then accept-and-reload on a hit edge
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    cont = 1'b1; cmp_val = 8'h05; cmp_load = 1'b1; arm = 1'b1;
    tick();
    cmp_load = 1'b0; arm = 1'b0;
    hits = 0;
    first_data = 16'h0000;
    for (int i = 0; i < 600 && hits < 2; i++) begin
      tick();
      if (match_pulse) begin
        hits++;
        if (hits == 1) first_data = m_evt_data;
      end
    end
    check("tp3_hits", hits, 2);
    check("tp3_ovf", evt_ovf, 1'b1);
    check("tp3_data_kept", evt_data, first_data);
    check("tp3_first_cnt", first_data[7:0], 8'h05);
    wait_count("tp3", 8'h05);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("tp3_reload_match", match_pulse, 1'b1);
    check("tp3_reload_valid", evt_valid, 1'b1);
    check("tp3_reload_wrap", evt_data[15:8], first_data[15:8] + 8'd2);

    // 4: hit on the wrap edge captures the incremented epoch
    cmp_val = 8'h00; cmp_load = 1'b1; evt_ready = 1'b1;
    tick();
    cmp_load = 1'b0;
    for (int i = 0; i < 2000 && m_wrap != 8'd7; i++) tick();
    check("tp4_wrap7", wrap_cnt, 8'd7);
    wait_match("tp4", 300);
    check("tp4_evt_data", evt_data, 16'h0800);
    check("tp4_wrap_pulse", wrap_pulse, 1'b1);

    // 5: disarm beats a match, arm+disarm -> IDLE, reset drops pending event
    cmp_val = 8'h40; cmp_load = 1'b1; evt_ready = 1'b0;
    tick();
    cmp_load = 1'b0;
    wait_count("tp5", 8'h40);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("tp5_no_hit", match_pulse, 1'b0);
    check("tp5_disarmed", armed, 1'b0);
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    check("tp5_arm_disarm", armed, 1'b0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("tp5_rearmed", armed, 1'b1);
    wait_match("tp5", 300);
    check("tp5_pending", evt_valid, 1'b1);
    pulse_reset("tp5_reset");
    tick();
    check("tp5_idle_after", armed, 1'b0);

    // 6: discontinuity 0x20 -> 0x22
    evt_ready = 1'b1;
    wait_count("tp6", 8'h20);
    tick();
    count = 8'h22;
    tick();
    check("tp6_step_err", step_err, STEP_EN);
    repeat (3) tick();
    check("tp6_step_sticky", step_err, STEP_EN);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 32)
        0: count = 8'($urandom);
        1: count = count - 8'd1;
        default: ;
      endcase
      cmp_val   = count + 8'($urandom_range(0, 12));
      cmp_load  = ($urandom % 8) == 0;
      arm       = ($urandom % 6) == 0;
      disarm    = ($urandom % 20) == 0;
      cont      = 1'($urandom % 2);
      evt_ready = ($urandom % 3) != 0;
      if (($urandom % 400) == 0) pulse_reset("rnd_reset");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_tracker.md
# count_tracker

Downstream monitor for the 8-bit free-running `counter` stage. It consumes the `count` bus and tracks wrap-arounds in an epoch counter. A small armed/hit state machine fires when `count` equals a programmable compare value, and each hit is captured as a timestamp event on a single-entry valid/ready output. Every output is registered.

## Interface
Parameters:
- `CNT_W`, default 8: width of `count` and `cmp_val`.
- `WRAP_W`, default 8: width of the wrap epoch counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `count`  in  CNT_W: counter value, sampled every cycle.
- `cmp_val`  in  CNT_W: compare value.
- `cmp_load`  in  1: loads `cmp_val` into `cmp_reg`.
- `arm`  in  1: IDLE→ARMED request.
- `disarm`  in  1: return to IDLE from any state.
- `cont`  in  1: continuous mode; after HIT, go back to ARMED instead of IDLE.
- `match_pulse`  out  1: high for exactly the HIT cycle.
- `wrap_pulse`  out  1: 1-cycle pulse per detected wrap.
- `wrap_cnt`  out  WRAP_W: wrap epoch count.
- `evt_valid`  out  1: event available.
- `evt_ready`  in  1: consumer accepts the event.
- `evt_data`  out  WRAP_W+CNT_W: {wrap_cnt, count} at the hit.
- `evt_ovf`  out  1: sticky flag; a hit was dropped.
- `step_err`  out  1: sticky discontinuity flag (see Configuration).
- `armed`  out  1: state is ARMED.

## Operation
- Internal registers: `prev_count`, `cmp_reg`, 2-bit state (IDLE=0, ARMED=1, HIT=2).
- Reset values, all zero: `prev_count`, `cmp_reg`, state=IDLE, `wrap_cnt`, `evt_data`, `evt_valid`, `evt_ovf`, `step_err`, `match_pulse`, `wrap_pulse`, `armed`.
- `prev_count` loads `count` every cycle.

Wrap detection:
- Condition: `prev_count` == all-ones and `count` == 0.
- On wrap: `wrap_pulse` is 1 for the next cycle, and `wrap_cnt` increments modulo 2^WRAP_W (all-ones → 0, no saturation).

Compare value:
- `cmp_load` writes `cmp_reg` at the edge.
- Compares always use the `cmp_reg` value from before that edge.

State machine (priority as listed):
- `disarm` → IDLE.
- IDLE: `arm` → ARMED.
- ARMED: `count` == `cmp_reg` → HIT.
- HIT: `cont`=1 → ARMED; `cont`=0 → IDLE. HIT always lasts exactly 1 cycle.
- `arm` while already ARMED or HIT is ignored.

Event capture, on the edge entering HIT:
- Captured data is {wrap_cnt_next, count}, where wrap_cnt_next includes any wrap detected at that same edge.
- `evt_valid`=0: load `evt_data`, set `evt_valid`.
- `evt_valid`=1 and `evt_ready`=1: load new data; `evt_valid` stays 1.
- `evt_valid`=1 and `evt_ready`=0: keep old data; set `evt_ovf`.

Event handshake and flag clearing:
- `evt_valid` & `evt_ready` with no new capture → `evt_valid` goes to 0.
- `evt_data` holds stable while `evt_valid`=1 and not accepted.
- `evt_ovf` and `step_err` clear only on reset.

Reset:
- Asserting `reset` mid-operation clears everything asynchronously, including a pending event.

## Timing
- `count` == `cmp_reg` sampled in ARMED at edge N → `match_pulse`=1 and `evt_valid`=1 after edge N, for cycle N+1.
- Wrap sampled at edge N → `wrap_pulse` and the new `wrap_cnt` visible in cycle N+1.
- With `cont`=1 and a counter incrementing once per cycle, hits occur every 2^CNT_W cycles.
- Latency from `arm` to ARMED: 1 cycle.
- Same-cycle `arm` and `disarm` → IDLE.
- `cmp_load` in the same cycle as a match: the match uses the old `cmp_reg`.

## Configuration
- Macro: `COUNT_TRACKER_STEP_CHECK_EN`.
- Defined: `step_err` is set when `count` ≠ `prev_count`+1 (mod 2^CNT_W) and `count` ≠ `prev_count`. The check is suppressed for the first cycle after reset deassertion.
- Undefined: checker logic is not built; `step_err` is tied to 0.

## Test plan
1. Reset with `count` stepping 0xFD→0xFE→0xFF→0x00 → `wrap_pulse` 1 cycle after 0x00 is sampled, `wrap_cnt`=1; all other outputs 0.
2. `cmp_val`=0x10 with `cmp_load`, `arm`, `cont`=0, `evt_ready`=0, `wrap_cnt`=3 → on `count`=0x10: `match_pulse` 1 cycle, `evt_data`=0x0310, `evt_valid` held, state IDLE.
3. `cont`=1, `cmp_reg`=0x05, `evt_ready`=0 for 300 cycles → second hit sets `evt_ovf`; `evt_data` keeps first value; with `evt_ready`=1 on the hit edge, `evt_valid` stays 1 with new data.
4. `cmp_reg`=0x00, hit coinciding with wrap 0xFF→0x00 at `wrap_cnt`=7 → `evt_data`=0x0800.
5. `disarm` together with a match, then `arm`; `reset` pulsed low while `evt_valid`=1 → no hit and IDLE; after reset all outputs 0.
6. With `COUNT_TRACKER_STEP_CHECK_EN` defined: `count` jump 0x20→0x22 → `step_err`=1, sticky. Without the macro: `step_err` stays 0.
